lsu_stage: RTL and testbench

Memory-access stage directly downstream of the execute stage. It takes the ALU result, store data and control bits over the valid/ready handshake. For loads and stores it runs one transaction on a single-outstanding request/response data-memory port. It then hands a registered writeback packet to the writeback stage over valid/ready. Non-memory instructions pass through with one cycle of latency.

---
 rtl/lsu_stage.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_lsu_stage.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// lsu_stage: memory-access stage between execute and writeback.
//
// Takes one instruction per handshake from execute. Loads and stores run a
// single outstanding transaction on the data-memory request/response port.
// Everything else passes straight to a registered writeback packet.
//
// Ports:
//   clock, reset                     clock; asynchronous active-low reset
//   valid_last/ready_last            input handshake from execute
//   ex_result, rs2_value, funct3,
//   mem_wen, mem_ren, rd, R_wen,
//   csr_wen                          instruction fields
//   dmem_req_*                       memory request (word address, strobes)
//   dmem_resp_*                      memory response (one pulse per request)
//   valid_next/ready_next            output handshake to writeback
//   wb_*                             registered writeback packet
//
// Optional feature macro: LSU_PERF_COUNT_EN. When it is defined, the ports
// load_count, store_count and stall_count (32-bit, wrapping) are added.
module lsu_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_last,
  output logic            ready_last,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [2:0]      funct3,
  input  logic            mem_wen,
  input  logic            mem_ren,
  input  logic [4:0]      rd,
  input  logic            R_wen,
  input  logic [3:0]      csr_wen,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_wen,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [3:0]      dmem_req_wstrb,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_rdata,
  input  logic            dmem_resp_err,
  output logic            valid_next,
  input  logic            ready_next,
  output logic [4:0]      wb_rd,
  output logic            wb_R_wen,
  output logic [3:0]      wb_csr_wen,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_misalign,
  output logic            wb_fault
`ifdef LSU_PERF_COUNT_EN
  ,
  output logic [31:0]     load_count,
  output logic [31:0]     store_count,
  output logic [31:0]     stall_count
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_e;

  // Last WAIT-cycle count value; reaching it without a response forces a fault.
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT) - 32'd1;

  // Load formatting: pick byte/half by lane, then sign- or zero-extend.
  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  load_fmt = {{24{b[7]}}, b};
      3'b001:  load_fmt = {{16{h[15]}}, h};
      3'b100:  load_fmt = {24'd0, b};
      3'b101:  load_fmt = {16'd0, h};
      default: load_fmt = rdata;
    endcase
  endfunction

  // Size comes from funct3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lane[0];
      default: is_misaligned = (lane != 2'd0);
    endcase
  endfunction

  function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   st_strb = 4'b0001 << lane;
      2'b01:   st_strb = 4'b0011 << lane;
      default: st_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   st_wdata = {4{d[7:0]}};
      2'b01:   st_wdata = {2{d[15:0]}};
      default: st_wdata = d;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_store_q, is_store_d;
  logic        rwen_q, rwen_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_wen_q, req_wen_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;
  logic        valid_q, valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_rwen_q, wb_rwen_d;
  logic [3:0]  wb_csr_q, wb_csr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_mis_q, wb_mis_d;
  logic        wb_fault_q, wb_fault_d;

  logic ready_raw, accept, in_mem, in_mis;

  assign ready_raw = (state_q == IDLE) || ((state_q == HOLD) && ready_next);
  // Gated with reset so every output reads 0 while reset is asserted.
  assign ready_last = reset && ready_raw;
  assign accept = valid_last && ready_raw;
  assign in_mem = mem_wen || mem_ren;
  assign in_mis = in_mem && is_misaligned(funct3, ex_result[1:0]);

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    rwen_d      = rwen_q;
    cnt_d       = cnt_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_wen_d   = req_wen_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    valid_d     = valid_q;
    wb_rd_d     = wb_rd_q;
    wb_rwen_d   = wb_rwen_q;
    wb_csr_d    = wb_csr_q;
    wb_data_d   = wb_data_q;
    wb_mis_d    = wb_mis_q;
    wb_fault_d  = wb_fault_q;

    case (state_q)
      REQ: begin
        if (dmem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
          cnt_d       = 32'd0;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (dmem_resp_valid) begin
          state_d    = HOLD;
          valid_d    = 1'b1;
          wb_fault_d = dmem_resp_err;
          if (is_store_q) begin
            wb_data_d = 32'd0;
            wb_rwen_d = 1'b0;
          end else begin
            wb_data_d = load_fmt(funct3_q, lane_q, dmem_resp_rdata);
            wb_rwen_d = rwen_q && !dmem_resp_err;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LIM)) begin
          state_d    = HOLD;
          valid_d    = 1'b1;
          wb_fault_d = 1'b1;
          wb_rwen_d  = 1'b0;
          wb_data_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      HOLD: begin
        if (ready_next) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new instruction (from IDLE or a releasing HOLD) overrides the above.
    if (accept) begin
      lane_d     = ex_result[1:0];
      funct3_d   = funct3;
      is_store_d = mem_wen;
      rwen_d     = R_wen;
      wb_rd_d    = rd;
      wb_csr_d   = csr_wen;
      wb_fault_d = 1'b0;
      wb_mis_d   = in_mis;
      if (!in_mem || in_mis) begin
        state_d   = HOLD;
        valid_d   = 1'b1;
        wb_data_d = ex_result;
        wb_rwen_d = R_wen && !in_mis;
      end else begin
        state_d     = REQ;
        valid_d     = 1'b0;
        wb_data_d   = 32'd0;
        wb_rwen_d   = 1'b0;
        req_valid_d = 1'b1;
        req_addr_d  = {ex_result[31:2], 2'b00};
        req_wen_d   = mem_wen;
        req_wdata_d = mem_wen ? st_wdata(funct3, rs2_value) : 32'd0;
        req_wstrb_d = mem_wen ? st_strb(funct3, ex_result[1:0]) : 4'd0;
      end
    end else begin
      lane_d = lane_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lane_q      <= 2'd0;
      funct3_q    <= 3'd0;
      is_store_q  <= 1'b0;
      rwen_q      <= 1'b0;
      cnt_q       <= 32'd0;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'd0;
      req_wen_q   <= 1'b0;
      req_wdata_q <= 32'd0;
      req_wstrb_q <= 4'd0;
      valid_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_rwen_q   <= 1'b0;
      wb_csr_q    <= 4'd0;
      wb_data_q   <= 32'd0;
      wb_mis_q    <= 1'b0;
      wb_fault_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      rwen_q      <= rwen_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_wen_q   <= req_wen_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      valid_q     <= valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_rwen_q   <= wb_rwen_d;
      wb_csr_q    <= wb_csr_d;
      wb_data_q   <= wb_data_d;
      wb_mis_q    <= wb_mis_d;
      wb_fault_q  <= wb_fault_d;
    end
  end

  assign dmem_req_valid = req_valid_q;
  assign dmem_req_addr  = req_addr_q;
  assign dmem_req_wen   = req_wen_q;
  assign dmem_req_wdata = req_wdata_q;
  assign dmem_req_wstrb = req_wstrb_q;
  assign valid_next     = valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_R_wen       = wb_rwen_q;
  assign wb_csr_wen     = wb_csr_q;
  assign wb_data        = wb_data_q;
  assign wb_misalign    = wb_mis_q;
  assign wb_fault       = wb_fault_q;

`ifdef LSU_PERF_COUNT_EN
  logic [31:0] load_cnt_q, store_cnt_q, stall_cnt_q;
  logic        done_s;

  // A memory op completes when its response arrives in WAIT.
  assign done_s = (state_q == WAIT) && dmem_resp_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_cnt_q  <= 32'd0;
      store_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (done_s && !is_store_q) load_cnt_q <= load_cnt_q + 32'd1;
      if (done_s && is_store_q)  store_cnt_q <= store_cnt_q + 32'd1;
      if ((state_q == REQ) || (state_q == WAIT)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;

  typedef struct {
    logic [4:0]  rd;
    logic        rwen;
    logic [3:0]  csr;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        fault;
  } pkt_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid_last = 1'b0;
  logic        ready_last;
  logic [31:0] ex_result = 32'd0;
  logic [31:0] rs2_value = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        mem_wen = 1'b0;
  logic        mem_ren = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic        R_wen = 1'b0;
  logic [3:0]  csr_wen = 4'd0;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_req_addr;
  logic        dmem_req_wen;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_resp_valid = 1'b0;
  logic [31:0] dmem_resp_rdata = 32'd0;
  logic        dmem_resp_err = 1'b0;
  logic        valid_next;
  logic        ready_next = 1'b1;
  logic [4:0]  wb_rd;
  logic        wb_R_wen;
  logic [3:0]  wb_csr_wen;
  logic [31:0] wb_data;
  logic        wb_misalign;
  logic        wb_fault;
`ifdef LSU_PERF_COUNT_EN
  logic [31:0] load_count, store_count, stall_count;
`endif

  lsu_stage #(.XLEN(32), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .valid_last(valid_last), .ready_last(ready_last),
    .ex_result(ex_result), .rs2_value(rs2_value), .funct3(funct3),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .rd(rd), .R_wen(R_wen), .csr_wen(csr_wen),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wen(dmem_req_wen),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .dmem_resp_err(dmem_resp_err),
    .valid_next(valid_next), .ready_next(ready_next),
    .wb_rd(wb_rd), .wb_R_wen(wb_R_wen), .wb_csr_wen(wb_csr_wen), .wb_data(wb_data),
    .wb_misalign(wb_misalign), .wb_fault(wb_fault)
`ifdef LSU_PERF_COUNT_EN
    , .load_count(load_count), .store_count(store_count), .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  pkt_t exp_q[$];
  req_t req_q[$];

  // Memory model configuration
  int          cfg_req_delay = 0;
  int          cfg_resp_delay = 0;
  bit          cfg_no_resp = 1'b0;
  logic [31:0] cfg_rdata = 32'd0;
  logic        cfg_err = 1'b0;

  task automatic chk(input string name, input bit ok, input logic [31:0] act,
                     input logic [31:0] expv);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic pkt_t mkp(input logic [4:0] r, input logic w, input logic [3:0] c,
                               input logic [31:0] d, input logic cd, input logic m,
                               input logic f);
    pkt_t p;
    p.rd = r; p.rwen = w; p.csr = c; p.data = d; p.chk_data = cd; p.mis = m; p.fault = f;
    return p;
  endfunction

  function automatic req_t mkr(input logic [31:0] a, input logic w, input logic [31:0] d,
                               input logic [3:0] s);
    req_t r;
    r.addr = a; r.wen = w; r.wdata = d; r.wstrb = s;
    return r;
  endfunction

  // Memory responder: raises req_ready after cfg_req_delay cycles of a pending
  // request, then answers once after cfg_resp_delay cycles (unless dropped).
  initial begin
    int mst = 0;
    int cnt = 0;
    forever begin
      @(negedge clock);
      dmem_req_ready  = 1'b0;
      dmem_resp_valid = 1'b0;
      if (mst == 0) begin
        if (dmem_req_valid) begin
          if (cnt >= cfg_req_delay) begin
            dmem_req_ready = 1'b1; mst = 1; cnt = 0;
          end else cnt++;
        end
      end else if (cfg_no_resp) begin
        mst = 0; cnt = 0;
      end else if (cnt >= cfg_resp_delay) begin
        dmem_resp_valid = 1'b1; dmem_resp_rdata = cfg_rdata; dmem_resp_err = cfg_err;
        mst = 0; cnt = 0;
      end else cnt++;
    end
  end

  // Request monitor: checks handshaked requests and field stability while stalled.
  initial begin
    bit   pend = 1'b0;
    req_t sv;
    req_t e;
    forever begin
      @(negedge clock); #1;
      if (!reset) begin
        pend = 1'b0;
      end else if (dmem_req_valid) begin
        if (pend)
          chk("req_stable", {sv.addr, sv.wen, sv.wdata, sv.wstrb} ==
              {dmem_req_addr, dmem_req_wen, dmem_req_wdata, dmem_req_wstrb},
              dmem_req_addr, sv.addr);
        if (req_q.size() == 0) begin
          chk("req_unexpected", 1'b0, dmem_req_addr, 32'd0);
          pend = 1'b0;
        end else if (dmem_req_ready) begin
          e = req_q.pop_front();
          chk("req_addr", dmem_req_addr == e.addr, dmem_req_addr, e.addr);
          chk("req_wen", dmem_req_wen == e.wen, {31'd0, dmem_req_wen}, {31'd0, e.wen});
          if (e.wen) begin
            chk("req_wdata", dmem_req_wdata == e.wdata, dmem_req_wdata, e.wdata);
            chk("req_wstrb", dmem_req_wstrb == e.wstrb, {28'd0, dmem_req_wstrb},
                {28'd0, e.wstrb});
          end
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          sv = mkr(dmem_req_addr, dmem_req_wen, dmem_req_wdata, dmem_req_wstrb);
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  // Writeback monitor: pops the scoreboard on each accepted packet.
  initial begin
    bit   pend = 1'b0;
    logic [42:0] sv;
    pkt_t e;
    forever begin
      @(negedge clock); #1;
      if (!reset) begin
        pend = 1'b0;
      end else if (valid_next) begin
        if (pend)
          chk("wb_stable", sv == {wb_rd, wb_R_wen, wb_csr_wen, wb_data, wb_misalign, wb_fault},
              wb_data, sv[33:2]);
        if (ready_next) begin
          pend = 1'b0;
          if (exp_q.size() == 0) begin
            chk("wb_unexpected", 1'b0, wb_data, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("wb_rd", wb_rd == e.rd, {27'd0, wb_rd}, {27'd0, e.rd});
            chk("wb_R_wen", wb_R_wen == e.rwen, {31'd0, wb_R_wen}, {31'd0, e.rwen});
            chk("wb_csr_wen", wb_csr_wen == e.csr, {28'd0, wb_csr_wen}, {28'd0, e.csr});
            if (e.chk_data) chk("wb_data", wb_data == e.data, wb_data, e.data);
            chk("wb_misalign", wb_misalign == e.mis, {31'd0, wb_misalign}, {31'd0, e.mis});
            chk("wb_fault", wb_fault == e.fault, {31'd0, wb_fault}, {31'd0, e.fault});
          end
        end else begin
          pend = 1'b1;
          sv = {wb_rd, wb_R_wen, wb_csr_wen, wb_data, wb_misalign, wb_fault};
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  // Present one instruction until accepted; expectations are queued at accept.
  task automatic issue(input logic [31:0] ex, input logic [31:0] d2, input logic [2:0] f3,
                       input logic w, input logic r, input logic [4:0] dst,
                       input logic rw, input logic [3:0] cw, input pkt_t p,
                       input bit has_req, input req_t rq, output int waited);
    ex_result = ex; rs2_value = d2; funct3 = f3; mem_wen = w; mem_ren = r;
    rd = dst; R_wen = rw; csr_wen = cw; valid_last = 1'b1;
    waited = 0;
    #1;
    while (!ready_last && waited < 50) begin
      @(negedge clock); #1; waited++;
    end
    if (!ready_last) chk("accept_timeout", 1'b0, 32'(waited), 32'd0);
    exp_q.push_back(p);
    if (has_req) req_q.push_back(rq);
    @(negedge clock);
    valid_last = 1'b0;
  endtask

  // Count negedges (first one = 1) until valid_next is seen.
  task automatic wait_valid(output int k);
    k = 1;
    #1;
    while (!valid_next && k < 40) begin
      @(negedge clock); #1; k++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {ready_last, dmem_req_valid, dmem_req_wen, dmem_req_wstrb, valid_next,
        wb_rd, wb_R_wen, wb_csr_wen, wb_misalign, wb_fault} == 20'd0,
        {12'd0, ready_last, dmem_req_valid, dmem_req_wen, dmem_req_wstrb, valid_next,
         wb_rd, wb_R_wen, wb_csr_wen, wb_misalign, wb_fault}, 32'd0);
    chk({tag, "_addr"}, dmem_req_addr == 32'd0, dmem_req_addr, 32'd0);
    chk({tag, "_wdata"}, dmem_req_wdata == 32'd0, dmem_req_wdata, 32'd0);
    chk({tag, "_wbdata"}, wb_data == 32'd0, wb_data, 32'd0);
  endtask

  req_t nr;
  initial nr = mkr(32'd0, 1'b0, 32'd0, 4'd0);

  initial begin
    int w;
    int k;
    repeat (2) @(negedge clock);
    #1 chk_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    #1 chk("ready_after_reset", ready_last == 1'b1, {31'd0, ready_last}, 32'd1);
    @(negedge clock);

    // ALU pass-through
    issue(32'h0000_1234, 32'd0, 3'd0, 1'b0, 1'b0, 5'd5, 1'b1, 4'h3,
          mkp(5'd5, 1'b1, 4'h3, 32'h0000_1234, 1'b1, 1'b0, 1'b0), 1'b0, nr, w);
    wait_valid(k);
    chk("alu_latency", k == 1, 32'(k), 32'd1);
    @(negedge clock);

    // LB / LBU at 0x1003
    cfg_rdata = 32'h80FF_FFFF;
    issue(32'h0000_1003, 32'd0, 3'b000, 1'b0, 1'b1, 5'd7, 1'b1, 4'h0,
          mkp(5'd7, 1'b1, 4'h0, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0), 1'b1,
          mkr(32'h0000_1000, 1'b0, 32'd0, 4'd0), w);
    wait_valid(k);
    chk("load_latency", k == 3, 32'(k), 32'd3);
    @(negedge clock);
    issue(32'h0000_1003, 32'd0, 3'b100, 1'b0, 1'b1, 5'd8, 1'b1, 4'h0,
          mkp(5'd8, 1'b1, 4'h0, 32'h0000_0080, 1'b1, 1'b0, 1'b0), 1'b1,
          mkr(32'h0000_1000, 1'b0, 32'd0, 4'd0), w);
    wait_valid(k); @(negedge clock);

    // LH upper half, LHU lower half, LW
    cfg_rdata = 32'h8001_7FFF;
    issue(32'h0000_1002, 32'd0, 3'b001, 1'b0, 1'b1, 5'd9, 1'b1, 4'h0,
          mkp(5'd9, 1'b1, 4'h0, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0), 1'b1,
          mkr(32'h0000_1000, 1'b0, 32'd0, 4'd0), w);
    wait_valid(k); @(negedge clock);
    cfg_rdata = 32'h1234_F00D;
    issue(32'h0000_1000, 32'd0, 3'b101, 1'b0, 1'b1, 5'd10, 1'b1, 4'h0,
          mkp(5'd10, 1'b1, 4'h0, 32'h0000_F00D, 1'b1, 1'b0, 1'b0), 1'b1,
          mkr(32'h0000_1000, 1'b0, 32'd0, 4'd0), w);
    wait_valid(k); @(negedge clock);
    cfg_rdata = 32'hCAFE_BABE;
    issue(32'h0000_1004, 32'd0, 3'b010, 1'b0, 1'b1, 5'd11, 1'b1, 4'h0,
          mkp(5'd11, 1'b1, 4'h0, 32'hCAFE_BABE, 1'b1, 1'b0, 1'b0), 1'b1,
          mkr(32'h0000_1004, 1'b0, 32'd0, 4'd0), w);
    wait_valid(k); @(negedge clock);

    // Stores: SH, SB, SW
    issue(32'h0000_2002, 32'hABCD_1234, 3'b001, 1'b1, 1'b0, 5'd3, 1'b1, 4'h0,
          mkp(5'd3, 1'b0, 4'h0, 32'd0, 1'b1, 1'b0, 1'b0), 1'b1,
          mkr(32'h0000_2000, 1'b1, 32'h1234_1234, 4'b1100), w);
    wait_valid(k); @(negedge clock);
    issue(32'h0000_2001, 32'h0000_00A5, 3'b000, 1'b1, 1'b0, 5'd3, 1'b0, 4'h0,
          mkp(5'd3, 1'b0, 4'h0, 32'd0, 1'b1, 1'b0, 1'b0), 1'b1,
          mkr(32'h0000_2000, 1'b1, 32'hA5A5_A5A5, 4'b0010), w);
    wait_valid(k); @(negedge clock);
    issue(32'h0000_2004, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b0, 5'd0, 1'b0, 4'h0,
          mkp(5'd0, 1'b0, 4'h0, 32'd0, 1'b1, 1'b0, 1'b0), 1'b1,
          mkr(32'h0000_2004, 1'b1, 32'hDEAD_BEEF, 4'b1111), w);
    wait_valid(k); @(negedge clock);

    // Misaligned LW: no bus access, one-cycle latency
    issue(32'h0000_3001, 32'd0, 3'b010, 1'b0, 1'b1, 5'd12, 1'b1, 4'h0,
          mkp(5'd12, 1'b0, 4'h0, 32'h0000_3001, 1'b1, 1'b1, 1'b0), 1'b0, nr, w);
    wait_valid(k);
    chk("misalign_latency", k == 1, 32'(k), 32'd1);
    @(negedge clock);

    // Request stalled 4 cycles, then bus error
    cfg_req_delay = 4; cfg_err = 1'b1; cfg_rdata = 32'h5555_5555;
    issue(32'h0000_4000, 32'd0, 3'b010, 1'b0, 1'b1, 5'd13, 1'b1, 4'h0,
          mkp(5'd13, 1'b0, 4'h0, 32'd0, 1'b0, 1'b0, 1'b1), 1'b1,
          mkr(32'h0000_4000, 1'b0, 32'd0, 4'd0), w);
    wait_valid(k);
    chk("stall_latency", k == 7, 32'(k), 32'd7);
    @(negedge clock);
    cfg_req_delay = 0; cfg_err = 1'b0;

    // No response: timeout after 8 WAIT cycles (HOLD seen at the 10th negedge)
    cfg_no_resp = 1'b1;
    issue(32'h0000_5000, 32'd0, 3'b010, 1'b0, 1'b1, 5'd14, 1'b1, 4'h0,
          mkp(5'd14, 1'b0, 4'h0, 32'd0, 1'b0, 1'b0, 1'b1), 1'b1,
          mkr(32'h0000_5000, 1'b0, 32'd0, 4'd0), w);
    wait_valid(k);
    chk("timeout_latency", k == 10, 32'(k), 32'd10);
    @(negedge clock);
    cfg_no_resp = 1'b0;

    // HOLD stalled 3 cycles, then back-to-back accept in the release cycle
    ready_next = 1'b0;
    issue(32'h0000_00AA, 32'd0, 3'd0, 1'b0, 1'b0, 5'd15, 1'b1, 4'h1,
          mkp(5'd15, 1'b1, 4'h1, 32'h0000_00AA, 1'b1, 1'b0, 1'b0), 1'b0, nr, w);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready_last", ready_last == 1'b0, {31'd0, ready_last}, 32'd0);
      chk("hold_valid", valid_next == 1'b1, {31'd0, valid_next}, 32'd1);
      @(negedge clock);
    end
    ready_next = 1'b1;
    issue(32'h0000_00BB, 32'd0, 3'd0, 1'b0, 1'b0, 5'd16, 1'b1, 4'h2,
          mkp(5'd16, 1'b1, 4'h2, 32'h0000_00BB, 1'b1, 1'b0, 1'b0), 1'b0, nr, w);
    chk("b2b_no_bubble", w == 0, 32'(w), 32'd0);
    wait_valid(k);
    chk("b2b_latency", k == 1, 32'(k), 32'd1);
    @(negedge clock);

    // Reset in WAIT; a late response must then be ignored
    cfg_resp_delay = 6;
    issue(32'h0000_6000, 32'd0, 3'b010, 1'b0, 1'b1, 5'd17, 1'b1, 4'h0,
          mkp(5'd17, 1'b1, 4'h0, 32'd0, 1'b0, 1'b0, 1'b0), 1'b1,
          mkr(32'h0000_6000, 1'b0, 32'd0, 4'd0), w);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    #1 chk_all_zero("wait_reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    #1;
    chk("late_resp_ignored", valid_next == 1'b0, {31'd0, valid_next}, 32'd0);
    chk("idle_after_reset", ready_last == 1'b1, {31'd0, ready_last}, 32'd1);
    cfg_resp_delay = 0;

    repeat (3) @(negedge clock);
    chk("exp_q_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    chk("req_q_drained", req_q.size() == 0, 32'(req_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
